// File: rtl/uart_tx_result.sv
// uart_tx_result: UART transmitter for result bytes.
// Bytes are written on i_valid, queued in a 2^FIFO_W entry FIFO and sent on RsTx
// using a free-running 16x oversampling baud tick.
// Build option: define UART_TX_PARITY_EN to add an even parity bit (8E1).
// Without it, frames are 8N1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for a queued byte
// START  | start bit (line low) for 16 ticks
// DATA   | DBIT data bits, LSB first, 16 ticks each
// PARITY | even parity of the byte, 16 ticks (UART_TX_PARITY_EN only)
// STOP   | line high for SB_TICK ticks
module uart_tx_result #(
  parameter int DBIT    = 8,
  parameter int DVSR    = 326,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2
) (
  input  logic            clock,
  input  logic            i_reset_n,
  input  logic [DBIT-1:0] i_data,
  input  logic            i_valid,
  output logic            RsTx,
  output logic            o_full,
  output logic            o_busy,
  output logic            o_overrun
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam int PW    = FIFO_W + 1;
  localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW    = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  // Reset: asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // Shift ones into the release chain.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Release synchronizer register.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // Baud generator.
  logic [CW-1:0] baud_q, baud_d;
  logic          tick;

  assign tick = (baud_q == CW'(DVSR - 1));

  // Free-running 0..DVSR-1 counter, tick on the last count.
  always_comb begin
    baud_d = tick ? '0 : baud_q + CW'(1);
  end

  // Baud counter register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) baud_q <= '0;
    else        baud_q <= baud_d;
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [DBIT-1:0] mem_q [DEPTH];
  logic [DBIT-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovr_q, ovr_d;
  logic            fifo_empty, fifo_full;
  logic            wr_en, pop;
  logic [DBIT-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_W] != rd_ptr_q[FIFO_W]) &&
                      (wr_ptr_q[FIFO_W-1:0] == rd_ptr_q[FIFO_W-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[FIFO_W-1:0]];
  // Full is judged on the registered state, so a pop in the same cycle does not make room.
  assign wr_en      = i_valid && !fifo_full;

  // FIFO write, pointer advance and sticky overrun.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q | (i_valid & fifo_full);
    if (wr_en) begin
      mem_d[wr_ptr_q[FIFO_W-1:0]] = i_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // FIFO registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Bit-level FSM.
  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Next state, counters and the line level for the state being entered.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          b_d     = fifo_head;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_head;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {1'b0, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RsTx is a flop, so its next value follows the next state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // FSM registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign RsTx      = tx_q;
  assign o_full    = fifo_full;
  assign o_busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx_result.sv
// Testbench for uart_tx_result: a receiver-style line sampler decodes frames and
// compares them with bytes generated here; flag behaviour checked from FIFO occupancy.
module tb_uart_tx_result;

  localparam int DBIT     = 8;
  localparam int DVSR     = 4;
  localparam int SB_TICK  = 16;
  localparam int FIFO_W   = 2;
  localparam int DEPTH    = 1 << FIFO_W;
  localparam int BITC     = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS    = 1;
`else
  localparam int PBITS    = 0;
`endif
  // Negedges from first low sample to the middle of the stop bit.
  localparam int STOP_OFF = BITC + BITC / 2 + (DBIT + PBITS) * BITC;
  // Fall of RsTx to return to idle: start bit + data/parity + stop.
  localparam int FRAME_LO = 15 * DVSR + 1 + (DBIT + PBITS) * BITC + SB_TICK * DVSR;
  localparam int FRAME_HI = 16 * DVSR + (DBIT + PBITS) * BITC + SB_TICK * DVSR;

  logic            clock;
  logic            i_reset_n;
  logic [DBIT-1:0] i_data;
  logic            i_valid;
  logic            RsTx;
  logic            o_full;
  logic            o_busy;
  logic            o_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_result #(
    .DBIT(DBIT), .DVSR(DVSR), .SB_TICK(SB_TICK), .FIFO_W(FIFO_W)
  ) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_data(i_data), .i_valid(i_valid),
    .RsTx(RsTx), .o_full(o_full), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Waits for a start bit, then samples each bit in its middle.
  task automatic rx_frame(input int tmo, output logic [DBIT-1:0] d, output logic p,
                          output logic stp, output int waited);
    d = '0; p = 1'b0; stp = 1'b0; waited = 0;
    while (RsTx !== 1'b0 && waited < tmo) begin
      @(negedge clock);
      waited++;
    end
    if (RsTx !== 1'b0) begin
      waited = -1;
      return;
    end
    repeat (BITC + BITC / 2) @(negedge clock);
    d[0] = RsTx;
    for (int i = 1; i < DBIT; i++) begin
      repeat (BITC) @(negedge clock);
      d[i] = RsTx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BITC) @(negedge clock);
    p = RsTx;
`endif
    repeat (BITC) @(negedge clock);
    stp = RsTx;
  endtask

  task automatic wait_idle(input string tag);
    int j;
    j = 0;
    while (o_busy !== 1'b0 && j < 3000) begin
      @(negedge clock);
      j++;
    end
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL %s_idle: o_busy=%b after %0d cycles, required 0", tag, o_busy, j);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      n_checks++;
      if (RsTx !== 1'b1) $display("FAIL reset_rstx cyc %0d: got %b required 1", c, RsTx);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL reset_busy cyc %0d: got %b required 0", c, o_busy);
      else n_pass++;
      n_checks++;
      if (o_full !== 1'b0) $display("FAIL reset_full cyc %0d: got %b required 0", c, o_full);
      else n_pass++;
      n_checks++;
      if (o_overrun !== 1'b0) $display("FAIL reset_overrun cyc %0d: got %b required 0", c, o_overrun);
      else n_pass++;
      i_valid = ~i_valid;
      i_data  = DBIT'($urandom);
    end
    i_valid = 1'b0;
    @(negedge clock);
    i_reset_n = 1'b1;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({RsTx, o_busy, o_full, o_overrun} !== 4'b1000)
      $display("FAIL reset_release: {RsTx,busy,full,ovr}=%b required 1000", {RsTx, o_busy, o_full, o_overrun});
    else n_pass++;
  endtask

  // One isolated frame: latency, content, parity, stop and frame length.
  task automatic test_frame(input logic [DBIT-1:0] v, input string tag);
    logic [DBIT-1:0] d;
    logic            p, stp;
    int              w, j;
    i_data  = v;
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || RsTx !== 1'b1)
      $display("FAIL %s_queued: busy=%b RsTx=%b required busy=1 RsTx=1", tag, o_busy, RsTx);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (RsTx !== 1'b0) $display("FAIL %s_start_latency: RsTx=%b required 0", tag, RsTx);
    else n_pass++;
    rx_frame(10, d, p, stp, w);
    n_checks++;
    if (w < 0) begin
      $display("FAIL %s_timeout: no start bit, required one", tag);
      return;
    end else n_pass++;
    n_checks++;
    if (d !== v) $display("FAIL %s_data: got %h required %h", tag, d, v);
    else n_pass++;
`ifdef UART_TX_PARITY_EN
    n_checks++;
    if (p !== ^v) $display("FAIL %s_parity: got %b required %b", tag, p, ^v);
    else n_pass++;
`endif
    n_checks++;
    if (stp !== 1'b1) $display("FAIL %s_stop: got %b required 1", tag, stp);
    else n_pass++;
    j = 0;
    while (o_busy !== 1'b0 && j < 200) begin
      @(negedge clock);
      j++;
    end
    n_checks++;
    if (o_busy !== 1'b0 || STOP_OFF + j < FRAME_LO || STOP_OFF + j > FRAME_HI)
      $display("FAIL %s_frame_len: busy=%b len=%0d required %0d..%0d", tag, o_busy, STOP_OFF + j, FRAME_LO, FRAME_HI);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DBIT-1:0] bytes [4];
    int              gaps  [4];
    int              n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        bytes[k] = DBIT'($urandom);
        gaps[k]  = $urandom_range(0, 2);
      end
      fork
        begin
          for (int k = 0; k < n; k++) begin
            i_data  = bytes[k];
            i_valid = 1'b1;
            @(negedge clock);
            i_valid = 1'b0;
            repeat (gaps[k]) @(negedge clock);
          end
        end
        begin
          logic [DBIT-1:0] d;
          logic            p, stp;
          int              w;
          for (int k = 0; k < n; k++) begin
            rx_frame(300, d, p, stp, w);
            n_checks++;
            if (w < 0 || d !== bytes[k] || stp !== 1'b1)
              $display("FAIL rand_frame it%0d #%0d: data=%h stop=%b wait=%0d required data=%h stop=1",
                       it, k, d, stp, w, bytes[k]);
            else n_pass++;
            if (w < 0) break;
`ifdef UART_TX_PARITY_EN
            n_checks++;
            if (p !== ^bytes[k]) $display("FAIL rand_parity it%0d #%0d: got %b required %b", it, k, p, ^bytes[k]);
            else n_pass++;
`endif
            if (k > 0) begin
              n_checks++;
              if (w < 20 || w > 40) $display("FAIL rand_b2b it%0d #%0d: gap %0d required 20..40", it, k, w);
              else n_pass++;
            end
          end
        end
      join
      wait_idle("rand");
      n_checks++;
      if (o_overrun !== 1'b0 || o_full !== 1'b0)
        $display("FAIL rand_flags it%0d: ovr=%b full=%b required 0 0", it, o_overrun, o_full);
      else n_pass++;
    end
  endtask

  // One byte in flight, then a 5-byte burst into the idle-popping-free FIFO.
  task automatic test_back_to_back();
    logic [DBIT-1:0] burst [5];
    logic [DBIT-1:0] exp_q [$];
    int              nf;
    burst[0] = 8'hA1; burst[1] = 8'hB2; burst[2] = 8'hC3; burst[3] = 8'hD4; burst[4] = 8'hE5;
    nf = 1 + ((DEPTH < 5) ? DEPTH : 5);
    exp_q.push_back(8'h3C);
    i_data  = 8'h3C;
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    fork
      begin
        int   cnt;
        logic ovr;
        cnt = 0;
        ovr = 1'b0;
        repeat (10) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
          i_data  = burst[k];
          i_valid = 1'b1;
          @(negedge clock);
          if (cnt < DEPTH) begin
            cnt++;
            exp_q.push_back(burst[k]);
          end else begin
            ovr = 1'b1;
          end
          n_checks++;
          if (o_full !== (cnt == DEPTH)) $display("FAIL burst_full w%0d: got %b required %b", k, o_full, cnt == DEPTH);
          else n_pass++;
          n_checks++;
          if (o_overrun !== ovr) $display("FAIL burst_overrun w%0d: got %b required %b", k, o_overrun, ovr);
          else n_pass++;
        end
        i_valid = 1'b0;
      end
      begin
        logic [DBIT-1:0] d, e;
        logic            p, stp;
        int              w;
        for (int k = 0; k < nf; k++) begin
          rx_frame(300, d, p, stp, w);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          n_checks++;
          if (w < 0 || d !== e || stp !== 1'b1)
            $display("FAIL burst_frame #%0d: data=%h stop=%b wait=%0d required data=%h stop=1", k, d, stp, w, e);
          else n_pass++;
          if (w < 0) break;
          if (k > 0) begin
            n_checks++;
            if (w < 20 || w > 40) $display("FAIL burst_b2b #%0d: gap %0d required 20..40", k, w);
            else n_pass++;
          end
          if (k == 1) begin
            n_checks++;
            if (o_full !== 1'b0) $display("FAIL burst_full_clear: got %b required 0", o_full);
            else n_pass++;
          end
        end
      end
    join
    wait_idle("burst");
    n_checks++;
    if (o_overrun !== 1'b1 || o_full !== 1'b0)
      $display("FAIL burst_end_flags: ovr=%b full=%b required 1 0", o_overrun, o_full);
    else n_pass++;
  endtask

  // Reset during data bit 3 of 0xF0 with a second byte still queued.
  task automatic test_reset_mid();
    int w, lows, busys;
    i_data  = 8'hF0;
    i_valid = 1'b1;
    @(negedge clock);
    i_data  = 8'h33;
    @(negedge clock);
    i_valid = 1'b0;
    w = 0;
    while (RsTx !== 1'b0 && w < 20) begin
      @(negedge clock);
      w++;
    end
    repeat (BITC + BITC / 2 + 3 * BITC) @(negedge clock);
    n_checks++;
    if (RsTx !== 1'b0) $display("FAIL rmid_bit3: RsTx=%b required 0", RsTx);
    else n_pass++;
    #1 i_reset_n = 1'b0;
    #1;
    n_checks++;
    if (RsTx !== 1'b1 || o_busy !== 1'b0) $display("FAIL rmid_async: RsTx=%b busy=%b required 1 0", RsTx, o_busy);
    else n_pass++;
    repeat (3) @(negedge clock);
    i_reset_n = 1'b1;
    lows  = 0;
    busys = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (RsTx !== 1'b1) lows++;
      if (o_busy !== 1'b0) busys++;
    end
    n_checks++;
    if (lows != 0 || busys != 0)
      $display("FAIL rmid_no_frame: low cycles=%0d busy cycles=%0d required 0 0", lows, busys);
    else n_pass++;
    n_checks++;
    if (o_overrun !== 1'b0) $display("FAIL rmid_overrun: got %b required 0", o_overrun);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame(8'h55, "b55");
    wait_idle("b55");
    test_frame(8'h07, "b07");
    wait_idle("b07");
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_result.md
# uart_tx_result

Transmit side of the UART link: accepts result bytes (e.g. the ALU output) on a valid strobe, buffers them in a small FIFO and serialises them onto the TX line as 8N1 frames (optional parity) using its own 16x oversampling baud tick. Sits between the ALU result path and the board `RsTx` pin, mirroring the receive chain (baud generator, FIFO, bit-level FSM) in the opposite direction.

## Interface
- `DBIT`, 8, data bits per frame, LSB first
- `DVSR`, 326, clocks per oversampling tick (16 ticks = 1 bit)
- `SB_TICK`, 16, ticks in stop bit (16 = 1 stop bit, 32 = 2)
- `FIFO_W`, 2, FIFO address bits; depth = 2^FIFO_W
- `clock`  in  1  system clock, all logic on rising edge
- `i_reset_n`  in  1  reset, asynchronous, active-low
- `i_data`  in  DBIT  byte to send
- `i_valid`  in  1  write strobe, one byte per high cycle
- `RsTx`  out  1  serial line, idle high
- `o_full`  out  1  FIFO full
- `o_busy`  out  1  FSM not idle or FIFO not empty
- `o_overrun`  out  1  sticky: a write was dropped because FIFO full

## Operation
- Reset (async assert, sync release): FIFO empty, FSM IDLE, baud counter 0, `RsTx`=1, `o_full`=0, `o_busy`=0, `o_overrun`=0.
- Baud counter free-runs 0..DVSR-1; `tick` high for one clock when counter = DVSR-1.
- FIFO write: `i_valid` && !`o_full` stores `i_data`. `i_valid` && `o_full` drops byte, sets `o_overrun` (cleared only by reset). Write and pop in same cycle on a full FIFO: write dropped (full evaluated before pop).
- FSM states IDLE, START, DATA, [PARITY], STOP; tick counter `s` (0..15 / 0..SB_TICK-1), bit counter `n` (0..DBIT-1), shift register `b`.
- IDLE: `RsTx`=1. If FIFO non-empty: pop head into `b`, `s`=0, go START (pop and transition same clock).
- START: `RsTx`=0. On tick: if `s`=15 then `s`=0, `n`=0, go DATA; else `s`++.
- DATA: `RsTx`=`b[0]`. On tick with `s`=15: `s`=0, shift `b` right; if `n`=DBIT-1 go PARITY (if enabled) else STOP; else `n`++.
- PARITY: `RsTx`= XOR of the popped byte (even parity). 16 ticks, then STOP.
- STOP: `RsTx`=1. On tick with `s`=SB_TICK-1 go IDLE.
- Back-to-back: byte queued during STOP starts its START in the clock after IDLE is entered; no extra idle bit.
- `RsTx` is registered (no glitches).

## Timing
- `i_valid` to FIFO non-empty: 1 clock. IDLE with non-empty FIFO to `RsTx` falling: 1 clock.
- Start bit length: 15*DVSR+1 to 16*DVSR clocks (free-running tick not aligned to frame start); each data/parity bit exactly 16*DVSR clocks; stop bit exactly SB_TICK*DVSR clocks.
- `o_full` updates the clock after the write that fills the FIFO; deasserts the clock after a pop.
- Reset mid-frame: `RsTx` goes 1 immediately (async), frame aborted, FIFO contents lost.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, frame 8E1 (start, DBIT data, even parity, stop).
- Undefined: no PARITY state, frame 8N1; DATA goes directly to STOP.

## Test plan
DVSR=4, SB_TICK=16, FIFO_W=2 for all (bit = 64 clocks).
- Reset: hold `i_reset_n`=0 with `i_valid` toggling -> `RsTx`=1, `o_busy`=0, `o_full`=0, `o_overrun`=0 throughout.
- Single byte 0x55 -> `RsTx`: 0, then 1,0,1,0,1,0,1,0 (64 clocks each), then 1 for 64 clocks; `o_busy` falls after stop; with `UART_TX_PARITY_EN`, parity bit 0 before stop.
- Byte 0x07 with `UART_TX_PARITY_EN` -> data 1,1,1,0,0,0,0,0, parity 1; without macro, stop directly after bit 7.
- Burst 0xA1,0xB2,0xC3,0xD4,0xE5 on 5 consecutive clocks -> `o_full` high after 4th write, 5th dropped, `o_overrun`=1; first four frames sent back-to-back, stop immediately followed by next start.
- Pull `i_reset_n` low during data bit 3 of 0xF0 -> `RsTx`=1 same cycle, after release no further frame, `o_overrun`=0.
